fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, width of the program counter and of the byte address driven to instruction memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL have parameter RESET_PC, default 32'hBFC0_0000, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall  input  1  hold the PC and the IF/ID register.
REQ-007 SHALL have port flush  input  1  squash the IF/ID register contents.
REQ-008 SHALL have port redirect  input  1  load branch_target into the PC.
REQ-009 SHALL have port branch_target  input  ADDRESS_WIDTH  redirect destination.
REQ-010 SHALL have port pc  output  ADDRESS_WIDTH  current fetch address, driven to instruction memory.
REQ-011 SHALL have port instr_in  input  DATA_WIDTH  word returned combinationally by instruction memory for pc.
REQ-012 SHALL have ports instr_d / pc_d / pc_plus4_d  output  DATA_WIDTH / ADDRESS_WIDTH / ADDRESS_WIDTH  IF/ID register contents.
REQ-013 SHALL have port valid_d  output  1  IF/ID holds a real instruction.
REQ-014 SHALL have port misalign_err  output  1  sticky misaligned-redirect flag.

Function
REQ-015 SHALL compute the next PC with priority redirect > stall > sequential: branch_target; hold; pc+4.
REQ-016 SHALL perform pc+4 modulo 2^ADDRESS_WIDTH, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-017 SHALL update the IF/ID register with priority flush > stall > capture: flush loads instr_d=NOP (32'h0000_0013), valid_d=0, and pc_d and pc_plus4_d unchanged; stall holds all fields; capture loads instr_in, pc, pc+4 and sets valid_d=1.
REQ-018 SHALL give a one-cycle fetch latency: the word at pc in cycle N appears on instr_d in cycle N+1.
REQ-019 SHALL, when redirect and stall are asserted together, still load branch_target into the PC, while the IF/ID register holds unless flush is also asserted.
REQ-020 SHALL not register pc combinationally from the inputs; pc is a direct register output.

Reset
REQ-021 SHALL, while rst_n=0, immediately force pc=RESET_PC, instr_d=NOP, pc_d=0, pc_plus4_d=0, valid_d=0 and misalign_err=0, independently of clk.
REQ-022 SHALL, on reset asserted mid-operation, discard any pending redirect or stall; the first capture after release fetches RESET_PC.

Configuration
REQ-023 SHALL, with FETCH_MISALIGN_CHECK_EN defined, set misalign_err=1 on a redirect with branch_target[1:0]!=0; the flag stays set until reset, and the PC is still loaded with branch_target[ADDRESS_WIDTH-1:2],2'b00.
REQ-024 SHALL, without FETCH_MISALIGN_CHECK_EN, clear branch_target[1:0] silently and tie misalign_err to 0.

Structure
REQ-025 SHALL place the NOP encoding, the RESET_PC default and the width defaults in package fetch_pkg, shared with the decode stage.
REQ-026 SHALL implement the PC register and next-PC selection as sub-module pc_reg; the IF/ID register and the misalignment logic stay in fetch_stage.

Verification
REQ-027 SHALL check reset: assert rst_n=0 mid-cycle -> pc=32'hBFC0_0000, valid_d=0, instr_d=32'h0000_0013 without a clock edge.
REQ-028 SHALL check sequential fetch: 4 idle cycles after release -> pc = BFC0_0000, _0004, _0008, _000C; pc_d lags pc by one cycle; valid_d=1 from the first edge.
REQ-029 SHALL check stall plus redirect: stall=1, redirect=1, target 32'h0000_0100 -> pc=0x100 next cycle, IF/ID unchanged; stall=1 alone for 3 cycles -> pc and IF/ID frozen.
REQ-030 SHALL check flush priority: flush=1 and stall=1 together -> valid_d=0, instr_d=NOP; the next normal cycle captures instr_in at the current pc.
REQ-031 SHALL check wrap-around: redirect to 32'hFFFF_FFFC, then one idle cycle -> pc=0, pc_plus4_d=0.
REQ-032 SHALL check misalignment: redirect to 32'h0000_0102 -> pc=0x100; misalign_err=1 and sticky with the macro defined, 0 without it.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: encodings and default widths shared by the fetch and decode stages.
package fetch_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: program counter register with redirect > stall > sequential next-PC selection.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W_DEF,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(RESET_PC_DEF)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] target,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4
);
  logic [ADDRESS_WIDTH-1:0] pc_next;
  assign pc_plus4 = pc + ADDRESS_WIDTH'(4);
  always_comb pc_next = redirect ? target : stall ? pc : pc_plus4;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= RESET_PC;
    else pc <= pc_next;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC plus IF/ID pipeline register; FETCH_MISALIGN_CHECK_EN enables the
// sticky misaligned-redirect flag.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(RESET_PC_DEF)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] branch_target,
  output logic [ADDRESS_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0]    instr_in,
  output logic [DATA_WIDTH-1:0]    instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic                     valid_d,
  output logic                     misalign_err
);
  localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP);
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic [ADDRESS_WIDTH-1:0] target;
  // Low address bits are always dropped; the PC stays word aligned.
  assign target = branch_target & ~ADDRESS_WIDTH'(3);
  pc_reg #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .redirect(redirect),
    .target(target),
    .pc(pc),
    .pc_plus4(pc_plus4)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr_d <= NOP_W;
      pc_d <= '0;
      pc_plus4_d <= '0;
      valid_d <= 1'b0;
    end else if (flush) begin
      instr_d <= NOP_W;
      valid_d <= 1'b0;
    end else if (!stall) begin
      instr_d <= instr_in;
      pc_d <= pc;
      pc_plus4_d <= pc_plus4;
      valid_d <= 1'b1;
    end
`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) misalign_err <= 1'b0;
    else if (redirect && |branch_target[1:0]) misalign_err <= 1'b1;
`else
  assign misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage; expected state is queued at drive time.
module tb_fetch_stage;
  localparam logic [31:0] NOP_C = 32'h0000_0013;
  localparam logic [31:0] RST_C = 32'hBFC0_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4d;
    logic v;
    logic me;
  } st_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic stall = 1'b0, flush = 1'b0, redirect = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc, instr_in, instr_d, pc_d, pc_plus4_d;
  logic valid_d, misalign_err;
  int checks = 0;
  int failures = 0;
  st_t m;
  st_t exp_q[$];
  always #5 clk = ~clk;
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  assign instr_in = imem(pc);
  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .redirect(redirect),
    .branch_target(branch_target), .pc(pc), .instr_in(instr_in), .instr_d(instr_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .misalign_err(misalign_err)
  );
  function automatic st_t snap();
    st_t s;
    s.pc = pc; s.instr = instr_d; s.pcd = pc_d; s.pc4d = pc_plus4_d;
    s.v = valid_d; s.me = misalign_err;
    return s;
  endfunction
  // Update the reference model, queue the expected post-edge state, apply one clock.
  task automatic drive(input logic st, input logic fl, input logic rd, input logic [31:0] tgt);
    logic [31:0] t;
    t = {tgt[31:2], 2'b00};
    if (fl) begin
      m.instr = NOP_C; m.v = 1'b0;
    end else if (!st) begin
      m.instr = imem(m.pc); m.pcd = m.pc; m.pc4d = m.pc + 32'd4; m.v = 1'b1;
    end
    m.pc = rd ? t : st ? m.pc : m.pc + 32'd4;
`ifdef FETCH_MISALIGN_CHECK_EN
    if (rd && tgt[1:0] != 2'b00) m.me = 1'b1;
`endif
    exp_q.push_back(m);
    stall = st; flush = fl; redirect = rd; branch_target = tgt;
    @(posedge clk);
    #1;
    stall = 1'b0; flush = 1'b0; redirect = 1'b0; branch_target = '0;
  endtask
  task automatic test_reset();
    @(posedge clk);
    stall = 1'b1; redirect = 1'b1; branch_target = 32'h0000_0400;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== RST_C) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, RST_C); end
    checks++;
    if (valid_d !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_d); end
    checks++;
    if (instr_d !== NOP_C) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr_d, NOP_C); end
    checks++;
    if (misalign_err !== 1'b0 || pc_d !== 32'd0 || pc_plus4_d !== 32'd0) begin
      failures++; $display("FAIL reset_misc got me=%b pcd=%h pc4d=%h exp 0/0/0", misalign_err, pc_d, pc_plus4_d);
    end
    @(posedge clk);
    #1;
    stall = 1'b0; redirect = 1'b0; branch_target = '0;
    rst_n = 1'b1;
    m = '{pc: RST_C, instr: NOP_C, pcd: 32'd0, pc4d: 32'd0, v: 1'b0, me: 1'b0};
  endtask
  task automatic test_sequential();
    st_t o, e;
    checks++;
    if (pc !== RST_C) begin failures++; $display("FAIL seq_pc0 got=%h exp=%h", pc, RST_C); end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'd0);
      e = exp_q.pop_front(); o = snap();
      checks++;
      if (o !== e) begin failures++; $display("FAIL seq_state%0d got=%h exp=%h", i, o, e); end
      checks++;
      if (pc_d !== RST_C + 32'(4 * (i - 1)) || valid_d !== 1'b1) begin
        failures++; $display("FAIL seq_lag%0d got pcd=%h v=%b exp pcd=%h v=1", i, pc_d, valid_d, RST_C + 32'(4 * (i - 1)));
      end
    end
  endtask
  task automatic test_stall_redirect();
    st_t o, e, held;
    held = snap();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    e = exp_q.pop_front(); o = snap();
    checks++;
    if (o !== e) begin failures++; $display("FAIL stallred_state got=%h exp=%h", o, e); end
    checks++;
    if (pc !== 32'h100 || instr_d !== held.instr || pc_d !== held.pcd || valid_d !== held.v) begin
      failures++; $display("FAIL stallred_hold got pc=%h pcd=%h exp pc=00000100 pcd=%h", pc, pc_d, held.pcd);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0);
      e = exp_q.pop_front(); o = snap();
      checks++;
      if (o !== e || pc !== 32'h100 || pc_d !== held.pcd) begin
        failures++; $display("FAIL stall_frozen%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask
  task automatic test_flush();
    st_t o, e;
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    e = exp_q.pop_front(); o = snap();
    checks++;
    if (o !== e || valid_d !== 1'b0 || instr_d !== NOP_C) begin
      failures++; $display("FAIL flush_state got=%h exp=%h", o, e);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    e = exp_q.pop_front(); o = snap();
    checks++;
    if (o !== e || instr_d !== imem(32'h100) || pc_d !== 32'h100) begin
      failures++; $display("FAIL flush_recover got=%h exp=%h", o, e);
    end
  endtask
  task automatic test_wrap();
    st_t o, e;
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    e = exp_q.pop_front(); o = snap();
    checks++;
    if (o !== e) begin failures++; $display("FAIL wrap_redirect got=%h exp=%h", o, e); end
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    e = exp_q.pop_front(); o = snap();
    checks++;
    if (o !== e || pc !== 32'd0 || pc_plus4_d !== 32'd0 || pc_d !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL wrap_state got=%h exp=%h", o, e);
    end
  endtask
  task automatic test_misalign();
    st_t o, e;
    logic exp_me;
`ifdef FETCH_MISALIGN_CHECK_EN
    exp_me = 1'b1;
`else
    exp_me = 1'b0;
`endif
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0102);
    e = exp_q.pop_front(); o = snap();
    checks++;
    if (o !== e || pc !== 32'h100 || misalign_err !== exp_me) begin
      failures++; $display("FAIL misalign_set got=%h exp=%h", o, e);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0200);
      e = exp_q.pop_front(); o = snap();
      checks++;
      if (o !== e || misalign_err !== exp_me) begin
        failures++; $display("FAIL misalign_sticky%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask
  task automatic test_back_to_back();
    st_t o, e;
    for (int i = 0; i < 6; i++) begin
      drive(i[0] & i[1], i == 4, i[0], 32'h0000_1000 + 32'(i * 16));
      e = exp_q.pop_front(); o = snap();
      checks++;
      if (o !== e) begin failures++; $display("FAIL b2b%0d got=%h exp=%h", i, o, e); end
    end
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_flush();
    test_wrap();
    test_misalign();
    test_back_to_back();
    test_reset();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL queue_drain got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
